// File: rtl/float_mac_pkg.sv
// float_mac_pkg
//   Shared widths and types for the float_MAC mantissa datapath.
//   MANT_W : mantissa operand width
//   HALF_W : width of one Karatsuba half
//   PROD_W : full mantissa product width
package float_mac_pkg;
  localparam int MANT_W = 12;
  localparam int HALF_W = 6;
  localparam int PROD_W = 24;

  typedef logic [MANT_W-1:0] mant_t;
  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/kara_mul_small.sv
// kara_mul_small
//   Unsigned combinational W x W -> 2W multiplier (schoolbook partial
//   products summed in a single combinational block).
// Ports
//   i_a  in   W    unsigned multiplicand
//   i_b  in   W    unsigned multiplier
//   o_p  out  2W   unsigned product i_a*i_b
module kara_mul_small #(
  parameter int W = 6
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  logic [2*W-1:0] w_pp [W];

  // One shifted copy of i_a per set bit of i_b.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_pp
      assign w_pp[gi] = i_b[gi] ? ({{W{1'b0}}, i_a} << gi) : '0;
    end
  endgenerate

  always_comb begin
    o_p = '0;
    for (int i = 0; i < W; i++) begin
      o_p = o_p + w_pp[i];
    end
  end

endmodule

// File: rtl/karatsuba_12bit.sv
// karatsuba_12bit
//   Unsigned 12x12 -> 24-bit multiplier for the float_MAC mantissa path.
//   One-level Karatsuba split into 6-bit halves (three narrow products),
//   two registered stages, one operand pair accepted per clock.
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   a/b carry a new pair this cycle
//   a          in   12  unsigned multiplicand
//   b          in   12  unsigned multiplier
//   out        out  24  registered product
//   out_valid  out  1   out holds the product of the pair accepted 2 edges earlier
module karatsuba_12bit
  import float_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] out,
  output logic              out_valid
);

  // Operand split and pre-adders.
  logic [HALF_W-1:0]     w_ah, w_al, w_bh, w_bl;
  logic [HALF_W:0]       w_sa, w_sb;
  logic [2*HALF_W-1:0]   w_z2, w_z0;
  logic [2*HALF_W+1:0]   w_zm;

  assign w_ah = a[MANT_W-1:HALF_W];
  assign w_al = a[HALF_W-1:0];
  assign w_bh = b[MANT_W-1:HALF_W];
  assign w_bl = b[HALF_W-1:0];

  // Max 63+63 = 126, so the 7-bit sums never wrap.
  assign w_sa = {1'b0, w_ah} + {1'b0, w_al};
  assign w_sb = {1'b0, w_bh} + {1'b0, w_bl};

  kara_mul_small #(.W(HALF_W))   u_mul_z2 (.i_a(w_ah), .i_b(w_bh), .o_p(w_z2));
  kara_mul_small #(.W(HALF_W))   u_mul_z0 (.i_a(w_al), .i_b(w_bl), .o_p(w_z0));
  kara_mul_small #(.W(HALF_W+1)) u_mul_zm (.i_a(w_sa), .i_b(w_sb), .o_p(w_zm));

  // Stage 1 registers.
  logic [2*HALF_W-1:0] r_z2, r_z0;
  logic [2*HALF_W+1:0] r_zm;
  logic                r_v1;

  // Stage 2 registers.
  prod_t               r_out;
  logic                r_out_valid;

  // Recombination. zm >= z2 + z0 always, so z1 never underflows; the final
  // sum is at most 0xFFE001, so 24-bit arithmetic loses nothing.
  logic [2*HALF_W+1:0] w_z1;
  prod_t               w_sum;

  assign w_z1  = r_zm - (2*HALF_W+2)'(r_z2) - (2*HALF_W+2)'(r_z0);
  assign w_sum = (PROD_W'(r_z2) << (2*HALF_W))
               + (PROD_W'(w_z1) << HALF_W)
               +  PROD_W'(r_z0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z2        <= '0;
      r_z0        <= '0;
      r_zm        <= '0;
      r_v1        <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Stages advance every cycle; the valid bit only qualifies the data.
      r_z2        <= w_z2;
      r_z0        <= w_z0;
      r_zm        <= w_zm;
      r_v1        <= in_valid;
      r_out       <= w_sum;
      r_out_valid <= r_v1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_karatsuba_12bit.sv
module tb_karatsuba_12bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] a, b;
  logic [23:0] out;
  logic        out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        v;
    logic [23:0] p;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  karatsuba_12bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out      (out),
    .out_valid(out_valid)
  );

  // One clock cycle: drive on the falling edge, update the scoreboard at the
  // rising edge, check #1 later. The queue holds the pair sitting in stage 1
  // plus the pair just sampled; the front is what out must now show.
  task automatic cyc(input logic rn, input logic v, input logic [11:0] ta,
                     input logic [11:0] tb, input string tag);
    exp_t e;
    exp_t z;
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    a        = ta;
    b        = tb;
    @(posedge clk);
    z.v = 1'b0;
    z.p = 24'd0;
    if (!rn) begin
      exp_q.delete();
      exp_q.push_back(z);
      e = z;
    end else begin
      e.v = v;
      e.p = 24'(ta) * 24'(tb);
      exp_q.push_back(e);
      if (exp_q.size() > 1) e = exp_q.pop_front();
      else e = z;
    end
    #1;
    n_cmp++;
    assert (out_valid === e.v) else begin
      n_fail++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, e.v);
    end
    n_cmp++;
    assert (out === e.p) else begin
      n_fail++;
      $error("FAIL %s out: got %06h want %06h", tag, out, e.p);
    end
    $display("%s rst_n=%b v=%b a=%03h b=%03h -> out=%06h out_valid=%b", tag, rn, v, ta, tb, out, out_valid);
  endtask

  initial begin
    logic [11:0] sa, sb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;

    // 1: reset held with live inputs
    repeat (3) cyc(1'b0, 1'b1, 12'hFFF, 12'hFFF, "reset");
    cyc(1'b1, 1'b0, 12'h000, 12'h000, "rel0");
    cyc(1'b1, 1'b0, 12'h000, 12'h000, "rel1");

    // 2: single pair
    cyc(1'b1, 1'b1, 12'd12, 12'd18, "basic");
    repeat (3) cyc(1'b1, 1'b0, 12'd0, 12'd0, "basic_idle");

    // 3: extremes back to back
    cyc(1'b1, 1'b1, 12'h000, 12'hABC, "ext0");
    cyc(1'b1, 1'b1, 12'hFFF, 12'hFFF, "ext1");
    cyc(1'b1, 1'b1, 12'h040, 12'h040, "ext2");
    cyc(1'b1, 1'b1, 12'h03F, 12'h03F, "ext3");
    cyc(1'b1, 1'b1, 12'h123, 12'h000, "ext4");
    repeat (2) cyc(1'b1, 1'b0, 12'd0, 12'd0, "ext_idle");

    // 4a: arithmetic sweep
    sa = 12'd12; sb = 12'd18;
    for (int i = 0; i < 500; i++) begin
      cyc(1'b1, 1'b1, sa, sb, "sweep");
      sa = sa + 12'd11;
      sb = sb + 12'd21;
    end

    // 4b: random operands, random valid
    for (int i = 0; i < 10000; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom), "rand");
    end

    // 5: reset mid-stream drops the two in-flight pairs
    cyc(1'b1, 1'b1, 12'h111, 12'h222, "mid0");
    cyc(1'b1, 1'b1, 12'h333, 12'h444, "mid1");
    cyc(1'b1, 1'b1, 12'h555, 12'h666, "mid2");
    cyc(1'b0, 1'b1, 12'h777, 12'h888, "mid_rst");
    cyc(1'b1, 1'b1, 12'h0AB, 12'h0CD, "mid3");
    cyc(1'b1, 1'b1, 12'hFED, 12'h321, "mid4");
    repeat (2) cyc(1'b1, 1'b0, 12'd0, 12'd0, "mid_idle");

    // 6: bubbles
    cyc(1'b1, 1'b1, 12'd3, 12'd5, "bub0");
    cyc(1'b1, 1'b0, 12'hA5A, 12'h5A5, "bub1");
    cyc(1'b1, 1'b1, 12'd7, 12'd9, "bub2");
    repeat (2) cyc(1'b1, 1'b0, 12'd0, 12'd0, "bub_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
